// File: rtl/data_ram_slave_if.sv
// data_ram_slave_if: MEM-stage <-> data-memory request/response bundle.
//   ce_i/we_i/addr_i/sel_i/data_i : request from the MEM stage
//   data_o/ready_o/stall_o/err_o  : response from the memory slave
// Signal names carry the slave's point of view (_i into the slave, _o out).
interface data_ram_slave_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        stall_o;
  logic        err_o;

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, ready_o, stall_o, err_o
  );

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, ready_o, stall_o, err_o
  );
endinterface

// File: rtl/data_ram_slave.sv
// data_ram_slave: data-memory responder for the MEM stage.
// Big-endian, byte-lane-writable array of 2^ADDR_WIDTH 32-bit words behind an
// IDLE/WAIT/ACK wait-state FSM. A request is accepted only in IDLE; it commits
// on the edge entering ACK and ready_o pulses for the single ACK cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset (array contents are not reset)
//   bus  : slave modport (ce/we/addr/sel/data in; data/ready/stall/err out)
module data_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_slave_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [0:DEPTH-1];

  logic                  commit;
  logic                  c_we;
  logic [31:0]           c_addr;
  logic [3:0]            c_sel;
  logic [31:0]           c_wdata;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic                  c_oor;

  // With zero wait cycles the commit happens on the accepting edge itself, so
  // the live inputs are used in IDLE; otherwise the latched copy is used.
  assign c_we    = (state_q == S_IDLE) ? bus.we_i   : we_q;
  assign c_addr  = (state_q == S_IDLE) ? bus.addr_i : addr_q;
  assign c_sel   = (state_q == S_IDLE) ? bus.sel_i  : sel_q;
  assign c_wdata = (state_q == S_IDLE) ? bus.data_i : wdata_q;
  assign c_idx   = c_addr[ADDR_WIDTH+1:2];
  assign c_oor   = (c_addr >> (ADDR_WIDTH + 2)) != 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ce_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bus.ce_i) begin
        we_q    <= bus.we_i;
        addr_q  <= bus.addr_i;
        sel_q   <= bus.sel_i;
        wdata_q <= bus.data_i;
      end
      // err is only ever high in the ACK cycle that follows a commit.
      err_q <= commit && c_oor;
      if (commit && !c_we)
        rdata_q <= c_oor ? 32'd0 : mem[c_idx];
    end
  end

  // Array write: gated by rst so an edge that resets the FSM never commits.
  always_ff @(posedge clk) begin
    if (rst && commit && c_we && !c_oor) begin
      for (int k = 0; k < 4; k++)
        if (c_sel[k]) mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
    end
  end

  assign bus.data_o  = rdata_q;
  assign bus.ready_o = (state_q == S_ACK);
  assign bus.err_o   = err_q;
  assign bus.stall_o = bus.ce_i & ~bus.ready_o;

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: three instances (WAIT_CYCLES = 1, 3, 0).
// Table-driven directed vectors and randomized traffic on the WAIT=1 unit
// against a word-array model; hand sequences for reset abort and back-to-back.
module tb_data_ram_slave;

  logic clk = 1'b0;
  logic rst0, rst1, rst3;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_ram_slave_if b0 ();
  data_ram_slave_if b1 ();
  data_ram_slave_if b3 ();

  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst0), .bus(b0));
  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst1), .bus(b1));
  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int u, input logic ce, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
    case (u)
      0: begin b0.ce_i = ce; b0.we_i = we; b0.addr_i = addr; b0.sel_i = sel; b0.data_i = data; end
      1: begin b1.ce_i = ce; b1.we_i = we; b1.addr_i = addr; b1.sel_i = sel; b1.data_i = data; end
      default: begin b3.ce_i = ce; b3.we_i = we; b3.addr_i = addr; b3.sel_i = sel; b3.data_i = data; end
    endcase
  endtask

  function automatic logic rdy(input int u);
    case (u)
      0: return b0.ready_o;
      1: return b1.ready_o;
      default: return b3.ready_o;
    endcase
  endfunction

  function automatic logic stl(input int u);
    case (u)
      0: return b0.stall_o;
      1: return b1.stall_o;
      default: return b3.stall_o;
    endcase
  endfunction

  function automatic logic ero(input int u);
    case (u)
      0: return b0.err_o;
      1: return b1.err_o;
      default: return b3.err_o;
    endcase
  endfunction

  function automatic logic [31:0] dat(input int u);
    case (u)
      0: return b0.data_o;
      1: return b1.data_o;
      default: return b3.data_o;
    endcase
  endfunction

  // Big-endian lane merge: sel[k] chooses byte k of the new word.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return r;
  endfunction

  // One request: present for one edge, then drop ce and scramble the bus to
  // show that the latched copy is what commits. Returns at the ACK cycle.
  task automatic do_req(input int u, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, output int lat, output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    set_req(u, 1'b1, we, addr, sel, data);
    @(posedge clk);
    #1 set_req(u, 1'b0, ~we, $urandom, 4'($urandom), $urandom);
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy(u)) begin
        lat = n; rd = dat(u); er = ero(u);
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_rd;   // read result; ignored for writes (data_o holds)
    logic        exp_err;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] model [int];
  logic [31:0] hold1;
  int          lat;
  logic [31:0] rd;
  logic        er;
  int          pulses;

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(3, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;

    chk("reset_data", dat(1), 32'd0);
    chk("reset_ready", 32'(rdy(1)), 32'd0);
    chk("reset_err", 32'(ero(1)), 32'd0);
    chk("reset_stall", 32'(stl(1)), 32'd0);

    // ---- directed table on WAIT_CYCLES=1 ----
    vecs = '{
      '{1'b1, 32'h10,   4'hF, 32'h11223344, 32'h0,        1'b0},
      '{1'b0, 32'h10,   4'hF, 32'h0,        32'h11223344, 1'b0},
      '{1'b1, 32'h20,   4'hF, 32'hAABBCCDD, 32'h0,        1'b0},
      '{1'b1, 32'h21,   4'h4, 32'h55555555, 32'h0,        1'b0},
      '{1'b0, 32'h20,   4'h1, 32'h0,        32'hAA55CCDD, 1'b0},
      '{1'b1, 32'h30,   4'hF, 32'h01020304, 32'h0,        1'b0},
      '{1'b1, 32'h31,   4'hC, 32'hBEEF0000, 32'h0,        1'b0},
      '{1'b0, 32'h30,   4'hF, 32'h0,        32'hBEEF0304, 1'b0},
      '{1'b1, 32'h30,   4'h0, 32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 32'h30,   4'h0, 32'h0,        32'hBEEF0304, 1'b0},
      '{1'b1, 32'h0,    4'hF, 32'h12345678, 32'h0,        1'b0},
      '{1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 32'h0,        1'b1},
      '{1'b0, 32'h0,    4'hF, 32'h0,        32'h12345678, 1'b0},
      '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h0,        1'b1},
      '{1'b0, 32'h10,   4'hF, 32'h0,        32'h11223344, 1'b0},
      '{1'b1, 32'hFFC,  4'hF, 32'h0F0E0D0C, 32'h0,        1'b0},
      '{1'b0, 32'hFFE,  4'h8, 32'h0,        32'h0F0E0D0C, 1'b0}
    };
    hold1 = 32'd0;
    foreach (vecs[i]) begin
      do_req(1, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, lat, rd, er);
      if (!vecs[i].we) hold1 = vecs[i].exp_rd;
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_data", i), rd, hold1);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      @(negedge clk);
      chk($sformatf("vec%0d_ready_drop", i), 32'(rdy(1)), 32'd0);
    end

    // Reset clears data_o but not the array.
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    chk("rst1_data", dat(1), 32'd0);
    do_req(1, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, er);
    chk("rst1_mem_kept", rd, 32'h11223344);
    hold1 = rd;

    // ---- randomized traffic vs word-array model ----
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_req(1, 1'b1, 32'h100 + 32'(4*i), 4'hF, model[i], lat, rd, er);
      chk("init_lat", 32'(lat), 32'd2);
    end
    for (int t = 0; t < 150; t++) begin
      logic        we, oor;
      int          i;
      logic [31:0] addr, data;
      logic [3:0]  sel;
      we   = 1'($urandom);
      i    = int'($urandom_range(0, 7));
      oor  = ($urandom_range(0, 9) == 0);
      addr = 32'h100 + 32'(4*i) + 32'($urandom_range(0, 3));
      if (oor) addr = addr | (32'($urandom_range(1, 32'hFFFFF)) << 12);
      sel  = 4'($urandom);
      data = $urandom;
      do_req(1, we, addr, sel, data, lat, rd, er);
      if (we && !oor) model[i] = merge(model[i], data, sel);
      if (!we) hold1 = oor ? 32'd0 : model[i];
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'd2);
      chk($sformatf("rnd%0d_data", t), rd, hold1);
      chk($sformatf("rnd%0d_err", t), 32'(er), 32'(oor));
    end

    // ---- reset during WAIT aborts the write (WAIT_CYCLES=3) ----
    do_req(3, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, lat, rd, er);
    chk("w3_lat", 32'(lat), 32'd4);
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
    @(posedge clk);
    #1 set_req(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 1) rst3 = 1'b1;
      if (rdy(3)) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    chk("abort_data", dat(3), 32'd0);
    chk("abort_err", 32'(ero(3)), 32'd0);
    do_req(3, 1'b0, 32'h40, 4'hF, 32'h0, lat, rd, er);
    chk("abort_lat", 32'(lat), 32'd4);
    chk("abort_word_kept", rd, 32'h0BADF00D);

    // ---- back-to-back held reads (WAIT_CYCLES=0) ----
    do_req(0, 1'b1, 32'h8, 4'hF, 32'h0A0A0A0A, lat, rd, er);
    chk("w0_lat_a", 32'(lat), 32'd1);
    do_req(0, 1'b1, 32'hC, 4'hF, 32'h0B0B0B0B, lat, rd, er);
    chk("w0_lat_b", 32'(lat), 32'd1);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    #1;
    chk("b2b_stall_pres", 32'(stl(0)), 32'd1);
    chk("b2b_ready_pres", 32'(rdy(0)), 32'd0);
    @(negedge clk);
    chk("b2b_ack1_ready", 32'(rdy(0)), 32'd1);
    chk("b2b_ack1_data", dat(0), 32'h0A0A0A0A);
    chk("b2b_ack1_stall", 32'(stl(0)), 32'd0);
    set_req(0, 1'b1, 1'b0, 32'hC, 4'hF, 32'h0);
    @(negedge clk);
    chk("b2b_bubble_ready", 32'(rdy(0)), 32'd0);
    chk("b2b_bubble_stall", 32'(stl(0)), 32'd1);
    @(negedge clk);
    chk("b2b_ack2_ready", 32'(rdy(0)), 32'd1);
    chk("b2b_ack2_data", dat(0), 32'h0B0B0B0B);
    chk("b2b_ack2_stall", 32'(stl(0)), 32'd0);
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(rdy(0)), 32'd0);
    chk("b2b_idle_stall", 32'(stl(0)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
